// File: rtl/nv_nvdla_sdp_cq_pkg.sv
// Shared helpers for the SDP context-queue FIFO: width math, write-limit decode, afull margin.
package nv_nvdla_sdp_cq_pkg;

    localparam int CQ_AFULL_MARGIN = 8;

    function automatic int cq_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // A zero or out-of-range runtime cap means "use the full depth".
    function automatic int eff_limit(input int cfg, input int depth);
        return ((cfg == 0) || (cfg > depth)) ? depth : cfg;
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_cq_ram.sv
// DEPTH x DW storage, one write and one read port; read data registered one edge after re.
// Read data holds while re is low, so the caller can stall on it; no backpressure of its own.
module nv_nvdla_sdp_cq_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 160,
    parameter int AW    = 8
) (
    input  logic          nvdla_core_clk,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [DW-1:0] di,
    input  logic [AW-1:0] ra,
    input  logic          re,
    output logic [DW-1:0] dout,
    input  logic [31:0]   pwrbus_ram_pd
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout_q;
    logic [DW-1:0] dout_d;
    logic          pwr_unused;

    // Power control only matters for a compiled macro.
    assign pwr_unused = ^pwrbus_ram_pd;

    always_comb begin
        dout_d = dout_q;
        if (re) begin
            dout_d = mem[ra];
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (we) begin
            mem[wa] <= di;
        end
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/nv_nvdla_sdp_cq_fifo.sv
// Context queue between SDP read-DMA issue and return; push to out_pvld is 2 cycles.
// in_prdy drops the cycle after occupancy reaches the runtime limit; out_pd/out_pvld hold while stalled.
module nv_nvdla_sdp_cq_fifo
    import nv_nvdla_sdp_cq_pkg::*;
#(
    parameter int DW       = 16,
    parameter int DEPTH    = 160,
    parameter int AW       = cq_clog2(DEPTH),
    parameter int CW       = cq_clog2(DEPTH + 1),
    parameter int AFULL_TH = (DEPTH > CQ_AFULL_MARGIN) ? DEPTH - CQ_AFULL_MARGIN : DEPTH
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          in_pvld,
    output logic          in_prdy,
    input  logic [DW-1:0] in_pd,
    output logic          out_pvld,
    input  logic          out_prdy,
    output logic [DW-1:0] out_pd,
    input  logic [CW-1:0] cfg_wr_limit,
    input  logic          flush,
    output logic [CW-1:0] wr_count,
    output logic          afull,
    output logic          empty,
    input  logic [31:0]   pwrbus_ram_pd
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] wr_count_q, wr_count_d, rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] eff_lim;
    logic          busy_q, busy_d, pop_q, pop_d;
    logic          rd_vld_q, rd_vld_d, out_pvld_q, out_pvld_d;
    logic          afull_q, afull_d, empty_q, empty_d;
    logic [DW-1:0] out_pd_q, out_pd_d, ram_dout;
    logic          push, pop, re, out_load;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign eff_lim  = CW'(eff_limit(int'(cfg_wr_limit), DEPTH));
    assign in_prdy  = !busy_q && !flush && !nvdla_core_rst;
    assign push     = in_pvld && in_prdy;
    assign pop      = out_pvld_q && out_prdy;
    assign out_load = rd_vld_q && (!out_pvld_q || out_prdy);
    // rd_cnt counts words still sitting unread in the RAM.
    assign re       = (rd_cnt_q != '0) && (!rd_vld_q || out_load);

    nv_nvdla_sdp_cq_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .nvdla_core_clk (nvdla_core_clk),
        .wa             (wr_ptr_q),
        .we             (push),
        .di             (in_pd),
        .ra             (rd_ptr_q),
        .re             (re),
        .dout           (ram_dout),
        .pwrbus_ram_pd  (pwrbus_ram_pd)
    );

    always_comb begin
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = re ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        rd_cnt_d   = rd_cnt_q + CW'(push) - CW'(re);
        // A slot is released one cycle after its pop, through pop_q.
        wr_count_d = wr_count_q + CW'(push) - CW'(pop_q);
        pop_d      = pop;
        busy_d     = (wr_count_d >= eff_lim);
        rd_vld_d   = re || (rd_vld_q && !out_load);
        out_pvld_d = out_load || (out_pvld_q && !out_prdy);
        out_pd_d   = out_load ? ram_dout : out_pd_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_cnt_d   = '0;
            wr_count_d = '0;
            pop_d      = 1'b0;
            busy_d     = 1'b0;
            rd_vld_d   = 1'b0;
            out_pvld_d = 1'b0;
            out_pd_d   = '0;
        end
        afull_d = (int'(wr_count_d) >= AFULL_TH);
        empty_d = (wr_count_d == '0) && !out_pvld_d;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            wr_count_q <= '0;
            pop_q      <= 1'b0;
            busy_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
            out_pvld_q <= 1'b0;
            out_pd_q   <= '0;
            afull_q    <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_count_q <= wr_count_d;
            pop_q      <= pop_d;
            busy_q     <= busy_d;
            rd_vld_q   <= rd_vld_d;
            out_pvld_q <= out_pvld_d;
            out_pd_q   <= out_pd_d;
            afull_q    <= afull_d;
            empty_q    <= empty_d;
        end
    end

    assign out_pvld = out_pvld_q;
    assign out_pd   = out_pd_q;
    assign wr_count = wr_count_q;
    assign afull    = afull_q;
    assign empty    = empty_q;

    a_count_bound: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        wr_count_q <= CW'(DEPTH));
    a_stall_stable: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        (out_pvld_q && !out_prdy && !flush) |=> (out_pvld_q && $stable(out_pd_q)));
    a_pop_valid: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        pop_q |-> (wr_count_q != '0));

endmodule

// File: tb/tb_nv_nvdla_sdp_cq_fifo.sv
// Directed bench for the context queue: a 160x16 instance for the table and corner sequences,
// and a 7x33 instance for random backpressure against a scoreboard.
module tb_nv_nvdla_sdp_cq_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_pvld, a_in_prdy, a_out_pvld, a_out_prdy, a_flush, a_afull, a_empty;
    logic [15:0] a_in_pd, a_out_pd;
    logic [7:0]  a_cfg, a_wr_count;

    logic        b_in_pvld, b_in_prdy, b_out_pvld, b_out_prdy, b_flush, b_afull, b_empty;
    logic [32:0] b_in_pd, b_out_pd;
    logic [2:0]  b_cfg, b_wr_count;

    nv_nvdla_sdp_cq_fifo #(.DW(16), .DEPTH(160)) u_a (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .in_pvld(a_in_pvld), .in_prdy(a_in_prdy), .in_pd(a_in_pd),
        .out_pvld(a_out_pvld), .out_prdy(a_out_prdy), .out_pd(a_out_pd),
        .cfg_wr_limit(a_cfg), .flush(a_flush), .wr_count(a_wr_count),
        .afull(a_afull), .empty(a_empty), .pwrbus_ram_pd(32'h0)
    );

    nv_nvdla_sdp_cq_fifo #(.DW(33), .DEPTH(7)) u_b (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .in_pvld(b_in_pvld), .in_prdy(b_in_prdy), .in_pd(b_in_pd),
        .out_pvld(b_out_pvld), .out_prdy(b_out_prdy), .out_pd(b_out_pd),
        .cfg_wr_limit(b_cfg), .flush(b_flush), .wr_count(b_wr_count),
        .afull(b_afull), .empty(b_empty), .pwrbus_ram_pd(32'h0)
    );

    typedef struct packed {
        logic        in_pvld;
        logic [15:0] in_pd;
        logic        out_prdy;
        logic [7:0]  lim;
        logic        exp_prdy;
        logic        exp_vld;
        logic [15:0] exp_pd;
        logic [7:0]  exp_cnt;
        logic        exp_empty;
    } vec_t;

    vec_t        vq[$];
    logic [32:0] sbq[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic ipv, input logic [15:0] ipd, input logic opr, input logic [7:0] lim,
                        input logic eprdy, input logic evld, input logic [15:0] epd,
                        input logic [7:0] ecnt, input logic eempty);
        vec_t v;
        v.in_pvld = ipv;    v.in_pd = ipd;     v.out_prdy = opr; v.lim = lim;
        v.exp_prdy = eprdy; v.exp_vld = evld;  v.exp_pd = epd;
        v.exp_cnt = ecnt;   v.exp_empty = eempty;
        vq.push_back(v);
    endtask

    initial begin
        int acc;
        int idx;
        int sent;
        int rcvd;
        logic stall_prev;

        // Limit 4 with output stalled, then limit released and the queue drained.
        addv(1'b1, 16'h0100, 1'b0, 8'd4, 1'b1, 1'b0, 16'h0000, 8'd1, 1'b0);
        addv(1'b1, 16'h0101, 1'b0, 8'd4, 1'b1, 1'b0, 16'h0000, 8'd2, 1'b0);
        addv(1'b1, 16'h0102, 1'b0, 8'd4, 1'b1, 1'b1, 16'h0100, 8'd3, 1'b0);
        addv(1'b1, 16'h0103, 1'b0, 8'd4, 1'b1, 1'b1, 16'h0100, 8'd4, 1'b0);
        addv(1'b1, 16'h0104, 1'b0, 8'd4, 1'b0, 1'b1, 16'h0100, 8'd4, 1'b0);
        addv(1'b1, 16'h0104, 1'b0, 8'd0, 1'b0, 1'b1, 16'h0100, 8'd4, 1'b0);
        addv(1'b1, 16'h0104, 1'b0, 8'd0, 1'b1, 1'b1, 16'h0100, 8'd5, 1'b0);
        addv(1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 1'b1, 16'h0101, 8'd5, 1'b0);
        addv(1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 1'b1, 16'h0102, 8'd4, 1'b0);
        addv(1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 1'b1, 16'h0103, 8'd3, 1'b0);
        addv(1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 1'b1, 16'h0104, 8'd2, 1'b0);
        addv(1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 1'b0, 16'h0000, 8'd1, 1'b0);
        addv(1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 1'b0, 16'h0000, 8'd0, 1'b1);

        rst = 1'b1;
        a_in_pvld = 1'b1; a_in_pd = 16'hAAAA; a_out_prdy = 1'b0; a_cfg = 8'd0; a_flush = 1'b0;
        b_in_pvld = 1'b0; b_in_pd = '0; b_out_prdy = 1'b0; b_cfg = 3'd0; b_flush = 1'b0;

        // Reset held for three edges while a write is offered.
        #1;
        chk("rst_prdy0", 64'(a_in_prdy), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_prdy", 64'(a_in_prdy), 64'(0));
            chk("rst_vld", 64'(a_out_pvld), 64'(0));
            chk("rst_cnt", 64'(a_wr_count), 64'(0));
            chk("rst_empty", 64'(a_empty), 64'(1));
            chk("rst_afull", 64'(a_afull), 64'(0));
            chk("rst_pd", 64'(a_out_pd), 64'(0));
        end
        rst = 1'b0;
        a_in_pvld = 1'b0;
        #1;
        chk("rel_prdy", 64'(a_in_prdy), 64'(1));
        chk("rel_prdy_b", 64'(b_in_prdy), 64'(1));
        tick();
        chk("rel_cnt", 64'(a_wr_count), 64'(0));
        chk("rel_empty", 64'(a_empty), 64'(1));

        foreach (vq[i]) begin
            a_in_pvld = vq[i].in_pvld; a_in_pd = vq[i].in_pd;
            a_out_prdy = vq[i].out_prdy; a_cfg = vq[i].lim;
            #1;
            chk($sformatf("vec%0d_prdy", i), 64'(a_in_prdy), 64'(vq[i].exp_prdy));
            tick();
            chk($sformatf("vec%0d_vld", i), 64'(a_out_pvld), 64'(vq[i].exp_vld));
            chk($sformatf("vec%0d_cnt", i), 64'(a_wr_count), 64'(vq[i].exp_cnt));
            chk($sformatf("vec%0d_empty", i), 64'(a_empty), 64'(vq[i].exp_empty));
            if (vq[i].exp_vld) begin
                chk($sformatf("vec%0d_pd", i), 64'(a_out_pd), 64'(vq[i].exp_pd));
            end
        end

        // Fill with output stalled: exactly DEPTH accepted, afull from 152.
        a_out_prdy = 1'b0; a_cfg = 8'd0;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            a_in_pvld = 1'b1; a_in_pd = 16'(i);
            #1;
            chk("fill_prdy", 64'(a_in_prdy), 64'(acc < 160));
            if (acc < 160) acc++;
            tick();
            chk("fill_afull", 64'(a_afull), 64'(acc >= 152));
        end
        chk("fill_cnt", 64'(a_wr_count), 64'(160));
        a_in_pvld = 1'b0; a_out_prdy = 1'b1;
        idx = 0;
        for (int k = 0; k < 400 && idx < 160; k++) begin
            #1;
            if (a_out_pvld) begin
                chk("drain_pd", 64'(a_out_pd), 64'(idx));
                idx++;
            end
            tick();
        end
        chk("drain_words", 64'(idx), 64'(160));
        tick();
        chk("drain_cnt", 64'(a_wr_count), 64'(0));
        chk("drain_empty", 64'(a_empty), 64'(1));
        chk("drain_afull", 64'(a_afull), 64'(0));
        tick();

        // Streaming 1000 words: two-cycle latency then one word per cycle across wraps.
        for (int k = 0; k < 1003; k++) begin
            a_in_pvld = (k < 1000); a_in_pd = 16'(k); a_out_prdy = 1'b1;
            #1;
            if (k < 1000) chk("stream_prdy", 64'(a_in_prdy), 64'(1));
            tick();
            chk("stream_vld", 64'(a_out_pvld), 64'((k >= 2) && (k <= 1001)));
            if ((k >= 2) && (k <= 1001)) chk("stream_pd", 64'(a_out_pd), 64'(16'(k - 2)));
        end
        a_in_pvld = 1'b0;
        tick(); tick();
        chk("stream_cnt", 64'(a_wr_count), 64'(0));

        // Flush with ten words queued and output stalled.
        a_out_prdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_in_pvld = 1'b1; a_in_pd = 16'(16'h0200 + i);
            tick();
        end
        a_in_pvld = 1'b0;
        tick(); tick();
        chk("flush_pre_cnt", 64'(a_wr_count), 64'(10));
        a_flush = 1'b1; a_in_pvld = 1'b1; a_in_pd = 16'hDEAD;
        #1;
        chk("flush_prdy", 64'(a_in_prdy), 64'(0));
        tick();
        a_flush = 1'b0;
        chk("flush_vld", 64'(a_out_pvld), 64'(0));
        chk("flush_cnt", 64'(a_wr_count), 64'(0));
        chk("flush_empty", 64'(a_empty), 64'(1));
        a_in_pvld = 1'b1; a_in_pd = 16'hBEEF; a_out_prdy = 1'b1;
        #1;
        chk("post_flush_prdy", 64'(a_in_prdy), 64'(1));
        tick();
        a_in_pvld = 1'b0;
        chk("post_flush_lat0", 64'(a_out_pvld), 64'(0));
        tick();
        chk("post_flush_lat1", 64'(a_out_pvld), 64'(0));
        tick();
        chk("post_flush_vld", 64'(a_out_pvld), 64'(1));
        chk("post_flush_pd", 64'(a_out_pd), 64'(16'hBEEF));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_flush_idle", 64'(a_out_pvld), 64'(0));
        end
        chk("post_flush_cnt", 64'(a_wr_count), 64'(0));
        chk("post_flush_empty", 64'(a_empty), 64'(1));

        // Random traffic and backpressure on the 7-deep, 33-bit queue.
        sent = 0; rcvd = 0; stall_prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            b_in_pvld  = (c < 2500) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_in_pd    = {1'($urandom_range(0, 1)), 32'(sent)};
            b_out_prdy = (c < 2500) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stall_prev) chk("bp_stall_vld", 64'(b_out_pvld), 64'(1));
            if (b_out_pvld) begin
                chk("bp_nonempty", 64'(sbq.size() != 0), 64'(1));
                if (sbq.size() != 0) begin
                    chk("bp_data", 64'(b_out_pd), 64'(sbq[0]));
                    if (b_out_prdy) begin
                        void'(sbq.pop_front());
                        rcvd++;
                    end
                end
            end
            if (b_in_pvld && b_in_prdy) begin
                sbq.push_back(b_in_pd);
                sent++;
            end
            stall_prev = b_out_pvld && !b_out_prdy;
            tick();
            chk("bp_cnt_bound", 64'(b_wr_count <= 3'd7), 64'(1));
        end
        chk("bp_traffic", 64'(sent > 100), 64'(1));
        chk("bp_left", 64'(sbq.size()), 64'(0));
        chk("bp_rcvd", 64'(rcvd), 64'(sent));
        chk("bp_empty", 64'(b_empty), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
